// File: rtl/fft_pkg.sv
// Shared register map, status bit positions, Q1.14 twiddle tables and the
// bit-reverse helper for the sequential FFT peripheral.
package fft_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_DATA_IN = 3'd1;
    localparam logic [2:0] REG_RD_IDX  = 3'd2;
    localparam logic [2:0] REG_RE_OUT  = 3'd3;
    localparam logic [2:0] REG_IM_OUT  = 3'd4;
    localparam int         NUM_REGS    = 5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } fft_state_e;

    // cos(2*pi*k/32) and sin(2*pi*k/32) in Q1.14; W = cos - j*sin.
    localparam logic signed [15:0] TW_COS [32] = '{
        16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
        16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
        16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
       -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
       -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623,
       -16'sd11585, -16'sd9102,  -16'sd6270,  -16'sd3196,
        16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
        16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069
    };

    localparam logic signed [15:0] TW_SIN [32] = '{
        16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
        16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069,
        16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
        16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
        16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
       -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
       -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623,
       -16'sd11585, -16'sd9102,  -16'sd6270,  -16'sd3196
    };

    function automatic logic [4:0] bitrev(input logic [4:0] v, input int log2n);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < log2n) r[log2n-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_periph_bfly.sv
// Combinational radix-2 DIT butterfly with divide-by-two scaling:
// top = (a + W*b)/2, bot = (a - W*b)/2, W = w_cos - j*w_sin in Q1.14.
module fft_bfly_r2 #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [15:0]   w_cos,
    input  logic signed [15:0]   w_sin,
    output logic signed [DW-1:0] y_top_re,
    output logic signed [DW-1:0] y_top_im,
    output logic signed [DW-1:0] y_bot_re,
    output logic signed [DW-1:0] y_bot_im
);
    localparam int PW = DW + 17;
    localparam int SW = DW + 3;

    logic signed [PW-1:0] t_re_full, t_im_full;
    logic signed [SW-1:0] t_re, t_im, a_re_x, a_im_x;
    logic signed [SW-1:0] s_top_re, s_top_im, s_bot_re, s_bot_im;

    always_comb begin
        t_re_full = PW'(w_cos) * PW'(b_re) + PW'(w_sin) * PW'(b_im);
        t_im_full = PW'(w_cos) * PW'(b_im) - PW'(w_sin) * PW'(b_re);
        t_re      = SW'(t_re_full >>> 14);
        t_im      = SW'(t_im_full >>> 14);
        a_re_x    = SW'(a_re);
        a_im_x    = SW'(a_im);
        s_top_re  = a_re_x + t_re;
        s_top_im  = a_im_x + t_im;
        s_bot_re  = a_re_x - t_re;
        s_bot_im  = a_im_x - t_im;
        y_top_re  = DW'(s_top_re >>> 1);
        y_top_im  = DW'(s_top_im >>> 1);
        y_bot_re  = DW'(s_bot_re >>> 1);
        y_bot_im  = DW'(s_bot_im >>> 1);
    end

endmodule

// File: rtl/fft_seq_periph.sv
// Sequential in-place radix-2 DIT FFT peripheral on the openMSP430 bus.
// Optional interrupt output irq_fft is built only when FFT_IRQ_EN is defined.
module fft_seq_periph
    import fft_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = 14'h0A0,
    parameter int          LOG2N     = 4,
    parameter int          DW        = 16
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout
`ifdef FFT_IRQ_EN
    ,
    output logic        irq_fft
`endif
);
    localparam int N  = 1 << LOG2N;
    localparam int CW = LOG2N + 1;
    localparam int BW = LOG2N - 1;

    fft_state_e state_q, state_d;
    logic [2:0]            stage_q, stage_d;
    logic [BW-1:0]         bfly_q, bfly_d;
    logic [CW-1:0]         count_q, count_d;
    logic [LOG2N-1:0]      rd_idx_q, rd_idx_d;
    logic                  ovf_q, ovf_d;
    logic signed [DW-1:0]  re_q [N];
    logic signed [DW-1:0]  re_d [N];
    logic signed [DW-1:0]  im_q [N];
    logic signed [DW-1:0]  im_d [N];

    logic                  busy, done, last_bfly;
    logic                  wr_en, rd_en, hit;
    logic [13:0]           offs;
    logic                  wr_ctrl, data_wr, rd_idx_wr, clr_cmd, start_cmd;
    logic signed [DW-1:0]  sample;
    logic [LOG2N-1:0]      wr_idx, j_ext, half, pos, top_idx, bot_idx;
    logic [4:0]            tw_idx;
    logic signed [DW-1:0]  y_top_re, y_top_im, y_bot_re, y_bot_im;

    // Bus decode; every command is dropped while the transform runs.
    assign wr_en     = per_en && (per_we == 2'b11);
    assign rd_en     = per_en && (per_we == 2'b00);
    assign offs      = per_addr - BASE_ADDR;
    assign hit       = (offs < 14'(NUM_REGS));
    assign wr_ctrl   = wr_en && hit && (offs[2:0] == REG_CTRL);
    assign data_wr   = wr_en && hit && (offs[2:0] == REG_DATA_IN) && !busy;
    assign rd_idx_wr = wr_en && hit && (offs[2:0] == REG_RD_IDX) && !busy;
    assign clr_cmd   = wr_ctrl && per_din[CTRL_CLR] && !busy;
    assign start_cmd = wr_ctrl && per_din[CTRL_START] && !per_din[CTRL_CLR] && !busy;
    assign sample    = per_din[DW-1:0];
    assign wr_idx    = LOG2N'(bitrev(5'(count_q[LOG2N-1:0]), LOG2N));
    assign last_bfly = (stage_q == 3'(LOG2N - 1)) && (bfly_q == '1);

    // Butterfly addressing; the twiddle index folds k*(32/N) into pos<<(4-s).
    always_comb begin
        j_ext   = {1'b0, bfly_q};
        half    = LOG2N'(1) << stage_q;
        pos     = j_ext & (half - LOG2N'(1));
        top_idx = ((j_ext >> stage_q) << (stage_q + 3'd1)) + pos;
        bot_idx = top_idx + half;
        tw_idx  = 5'(pos) << (3'd4 - stage_q);
    end

    fft_bfly_r2 #(.DW(DW)) u_bfly (
        .a_re     (re_q[top_idx]),
        .a_im     (im_q[top_idx]),
        .b_re     (re_q[bot_idx]),
        .b_im     (im_q[bot_idx]),
        .w_cos    (TW_COS[tw_idx]),
        .w_sin    (TW_SIN[tw_idx]),
        .y_top_re (y_top_re),
        .y_top_im (y_top_im),
        .y_bot_re (y_bot_re),
        .y_bot_im (y_bot_im)
    );

    always_ff @(posedge mclk) begin
        if (puc_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_cmd) state_d = S_COMPUTE;
            S_COMPUTE: if (last_bfly) state_d = S_DONE;
            S_DONE: begin
                if (clr_cmd || data_wr) state_d = S_IDLE;
                else if (start_cmd)     state_d = S_COMPUTE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_COMPUTE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        ovf_d    = ovf_q;
        re_d     = re_q;
        im_d     = im_q;
        if (busy) begin
            bfly_d = bfly_q + BW'(1);
            if (bfly_q == '1) stage_d = stage_q + 3'd1;
            re_d[top_idx] = y_top_re;
            im_d[top_idx] = y_top_im;
            re_d[bot_idx] = y_bot_re;
            im_d[bot_idx] = y_bot_im;
        end else if (clr_cmd) begin
            for (int i = 0; i < N; i++) begin
                re_d[i] = '0;
                im_d[i] = '0;
            end
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (data_wr) begin
            if (done) begin
                // First sample after a finished transform starts a new frame.
                for (int i = 0; i < N; i++) begin
                    re_d[i] = '0;
                    im_d[i] = '0;
                end
                re_d[0] = sample;
                count_d = CW'(1);
                ovf_d   = 1'b0;
            end else if (count_q == CW'(N)) begin
                ovf_d = 1'b1;
            end else begin
                re_d[wr_idx] = sample;
                im_d[wr_idx] = '0;
                count_d      = count_q + CW'(1);
            end
        end
        if (start_cmd) begin
            stage_d = '0;
            bfly_d  = '0;
        end
        if (rd_idx_wr) rd_idx_d = per_din[LOG2N-1:0];
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            stage_q  <= '0;
            bfly_q   <= '0;
            count_q  <= '0;
            rd_idx_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            ovf_q    <= ovf_d;
            re_q     <= re_d;
            im_q     <= im_d;
        end
    end

    always_comb begin
        per_dout = '0;
        if (rd_en && hit) begin
            case (offs[2:0])
                REG_CTRL:   per_dout = {7'd0, 6'(count_q), ovf_q, done, busy};
                REG_RD_IDX: per_dout = 16'(rd_idx_q);
                REG_RE_OUT: if (!busy) per_dout = 16'(re_q[rd_idx_q]);
                REG_IM_OUT: if (!busy) per_dout = 16'(im_q[rd_idx_q]);
                default:    per_dout = '0;
            endcase
        end
    end

`ifdef FFT_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (clr_cmd || start_cmd) irq_d = 1'b0;
        if (busy && last_bfly)    irq_d = 1'b1;
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign irq_fft = irq_q;
`endif

endmodule
